// File: rtl/store_merge_rmw.sv
// store_merge_rmw: sub-word store via read-modify-write; STORE_MISALIGN_TRAP_EN enables the misaligned-store trap
module store_merge_rmw #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              done,
`ifdef STORE_MISALIGN_TRAP_EN
    output logic              err,
`endif
    output logic              busy
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d, buf_q, buf_d, shifted, merged;
    logic [OW-1:0]     off_q, off_d, off_raw, lane_mask;
    logic [NB-1:0]     bmask_q, bmask_d, bmask_new;
    logic              rdy_q, full;
`ifdef STORE_MISALIGN_TRAP_EN
    logic              misaligned;
    assign misaligned = |(off_raw & lane_mask);
`endif
    // Decode the request: full-width test, in-word offset rounded to the size, byte-enable mask
    always_comb begin
        full      = {1'b0, req_size} >= 3'(OW);
        off_raw   = req_addr[OW-1:0];
        lane_mask = OW'((1 << req_size) - 1);
        bmask_new = NB'(((1 << (1 << req_size)) - 1) << (off_raw & ~lane_mask));
    end
    // Overlay the store bytes onto the word read back from memory
    always_comb begin
        shifted = data_q << {off_q, 3'b000};
        merged  = mem_rdata;
        for (int i = 0; i < NB; i++)
            if (bmask_q[i]) merged[8*i +: 8] = shifted[8*i +: 8];
    end
    // Next-state and datapath capture
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        off_d   = off_q;
        bmask_d = bmask_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                addr_d  = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                data_d  = req_data;
                off_d   = off_raw & ~lane_mask;
                bmask_d = bmask_new;
                buf_d   = full ? req_data : buf_q;
`ifdef STORE_MISALIGN_TRAP_EN
                state_d = misaligned ? ERR : full ? WR : RD;
`else
                state_d = full ? WR : RD;
`endif
            end
            RD:   state_d = WAIT;
            WAIT: begin
                buf_d   = merged;
                state_d = WR;
            end
            default: state_d = IDLE;
        endcase
    end
    // State registers; rdy_q holds req_ready low until the first edge after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            off_q   <= '0;
            bmask_q <= '0;
            buf_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            off_q   <= off_d;
            bmask_q <= bmask_d;
            buf_q   <= buf_d;
            rdy_q   <= 1'b1;
        end
    end
    assign req_ready = rdy_q && state_q == IDLE;
    assign mem_addr  = addr_q;
    assign mem_re    = state_q == RD;
    assign mem_we    = state_q == WR;
    assign mem_wdata = buf_q;
    assign done      = state_q == WR;
    assign busy      = state_q != IDLE;
`ifdef STORE_MISALIGN_TRAP_EN
    assign err       = state_q == ERR;
`endif
endmodule
